// File: rtl/arf104b256e1r1w0cbbehcaa4acw_port_ctrl_pkg.sv
// Shared types and sizes for the 256x104 1R1W register-file port sequencer.
// Optional feature macro (used by the top): ARF104B256E1R1W0CBBEHCAA4ACW_PORT_CTRL_BYPASS_EN
package arf104b256e1r1w0cbbehcaa4acw_port_ctrl_pkg;

    localparam int DWIDTH = 104;
    localparam int DEPTH  = 256;
    localparam int AWIDTH = $clog2(DEPTH);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/arf104b256e1r1w0cbbehcaa4acw_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester that was not granted
// last wins; the priority pointer moves only when a grant is actually issued.
module arf104b256e1r1w0cbbehcaa4acw_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    // requester that wins a tie
    logic r_ptr;
    logic [1:0] w_gnt;

    // one-hot grant: lone requester wins, tie goes to the pointer
    always_comb begin
        w_gnt = 2'b00;
        case (i_req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
            default: w_gnt = 2'b00;
        endcase
    end

    assign o_gnt = w_gnt;

    // after granting requester k, the other one gets priority
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_ptr <= 1'b0;
        else if (i_advance && (|w_gnt))
            r_ptr <= w_gnt[0];
    end

endmodule

// File: rtl/arf104b256e1r1w0cbbehcaa4acw_port_ctrl.sv
// Port sequencer for the 256x104 1R1W register-file array.
// Clears the array after reset (or on init_req), then arbitrates the write
// port between two requesters and sequences single-cycle-latency reads.
// Macro ARF104B256E1R1W0CBBEHCAA4ACW_PORT_CTRL_BYPASS_EN: when defined, a read
// colliding with a same-cycle write to the same address returns the new data.
module arf104b256e1r1w0cbbehcaa4acw_port_ctrl
    import arf104b256e1r1w0cbbehcaa4acw_port_ctrl_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_init_req,
    output logic                   o_init_done,
    input  logic [1:0]             i_wr_valid,
    input  logic [1:0][AWIDTH-1:0] i_wr_addr,
    input  logic [1:0][DWIDTH-1:0] i_wr_data,
    output logic [1:0]             o_wr_ready,
    input  logic                   i_rd_valid,
    input  logic [AWIDTH-1:0]      i_rd_addr,
    output logic                   o_rd_ready,
    output logic                   o_rsp_valid,
    output logic [DWIDTH-1:0]      o_rsp_data,
    output logic                   o_arr_wr_en,
    output logic [AWIDTH-1:0]      o_arr_wr_addr,
    output logic [DWIDTH-1:0]      o_arr_wr_data,
    output logic                   o_arr_rd_en,
    output logic [AWIDTH-1:0]      o_arr_rd_addr,
    input  logic [DWIDTH-1:0]      i_arr_rd_data
);

    state_t            r_state;
    logic [AWIDTH-1:0] r_cnt;
    logic              r_init_done;
    logic              r_rsp_valid;

    wr_req_t [1:0]     w_req;
    wr_req_t           w_sel;
    logic [1:0]        w_gnt;
    logic              w_run;
    logic              w_sweep;
    logic              w_rd_acc;

    // Array-facing controls are qualified with the reset input so every port
    // reads zero while reset is held, even though the FSM parks in INIT.
    assign w_run    = (r_state == RUN)  && i_rst;
    assign w_sweep  = (r_state == INIT) && i_rst;
    assign w_rd_acc = i_rd_valid && w_run;

    assign w_req[0] = '{valid: i_wr_valid[0], addr: i_wr_addr[0], data: i_wr_data[0]};
    assign w_req[1] = '{valid: i_wr_valid[1], addr: i_wr_addr[1], data: i_wr_data[1]};
    assign w_sel    = w_gnt[1] ? w_req[1] : w_req[0];

    arf104b256e1r1w0cbbehcaa4acw_rr_arb2 u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_wr_valid & {2{w_run}}),
        .i_advance (w_run),
        .o_gnt     (w_gnt)
    );

    assign o_wr_ready    = w_gnt;
    assign o_rd_ready    = w_run;
    assign o_arr_rd_en   = w_rd_acc;
    assign o_arr_rd_addr = w_rd_acc ? i_rd_addr : '0;
    assign o_init_done   = r_init_done;
    assign o_rsp_valid   = r_rsp_valid;

    // write port mux: sweep clear in INIT, granted requester in RUN
    always_comb begin
        o_arr_wr_en   = 1'b0;
        o_arr_wr_addr = '0;
        o_arr_wr_data = '0;
        if (w_sweep) begin
            o_arr_wr_en   = 1'b1;
            o_arr_wr_addr = r_cnt;
        end else if ((|w_gnt) && w_sel.valid) begin
            o_arr_wr_en   = 1'b1;
            o_arr_wr_addr = w_sel.addr;
            o_arr_wr_data = w_sel.data;
        end
    end

    // INIT/RUN sequencer with the sweep counter and registered status flags
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            // a read accepted on the init_req cycle still gets its response
            r_rsp_valid <= w_rd_acc;
            case (r_state)
                INIT: begin
                    // counter holds at the last entry instead of wrapping
                    if (r_cnt == AWIDTH'(DEPTH - 1)) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + AWIDTH'(1);
                    end
                end
                RUN: begin
                    if (i_init_req) begin
                        r_state     <= INIT;
                        r_cnt       <= '0;
                        r_init_done <= 1'b0;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

`ifdef ARF104B256E1R1W0CBBEHCAA4ACW_PORT_CTRL_BYPASS_EN
    logic              r_byp_hit;
    logic [DWIDTH-1:0] r_byp_data;

    // capture write data when a read hits the address being written this cycle
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_byp_hit  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp_hit <= w_rd_acc && (|w_gnt) && (w_sel.addr == i_rd_addr);
            if (w_rd_acc && (|w_gnt) && (w_sel.addr == i_rd_addr))
                r_byp_data <= w_sel.data;
        end
    end

    assign o_rsp_data = !r_rsp_valid ? '0 :
                        r_byp_hit    ? r_byp_data : i_arr_rd_data;
`else
    // array is read-before-write, so a colliding read returns the old data
    assign o_rsp_data = r_rsp_valid ? i_arr_rd_data : '0;
`endif

endmodule

// File: tb/tb_arf104b256e1r1w0cbbehcaa4acw_port_ctrl.sv
// Directed bench for the register-file port sequencer with a behavioural
// 1R1W array model and a read-response scoreboard.
module tb_arf104b256e1r1w0cbbehcaa4acw_port_ctrl;

    localparam int DW = 104;
    localparam int AW = 8;
    localparam int DP = 256;

    logic               clk = 1'b0;
    logic               rst;
    logic               init_req;
    logic               init_done;
    logic [1:0]         wr_valid;
    logic [1:0][AW-1:0] wr_addr;
    logic [1:0][DW-1:0] wr_data;
    logic [1:0]         wr_ready;
    logic               rd_valid;
    logic [AW-1:0]      rd_addr;
    logic               rd_ready;
    logic               rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               arr_wr_en;
    logic [AW-1:0]      arr_wr_addr;
    logic [DW-1:0]      arr_wr_data;
    logic               arr_rd_en;
    logic [AW-1:0]      arr_rd_addr;
    logic [DW-1:0]      arr_rd_data;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb_q[$];

    logic [DW-1:0] mem [DP];
    logic [DW-1:0] D0, D1, PA5, exp4;

    arf104b256e1r1w0cbbehcaa4acw_port_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_init_req    (init_req),
        .o_init_done   (init_done),
        .i_wr_valid    (wr_valid),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .o_wr_ready    (wr_ready),
        .i_rd_valid    (rd_valid),
        .i_rd_addr     (rd_addr),
        .o_rd_ready    (rd_ready),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_data    (rsp_data),
        .o_arr_wr_en   (arr_wr_en),
        .o_arr_wr_addr (arr_wr_addr),
        .o_arr_wr_data (arr_wr_data),
        .o_arr_rd_en   (arr_rd_en),
        .o_arr_rd_addr (arr_rd_addr),
        .i_arr_rd_data (arr_rd_data)
    );

    always #5 clk = ~clk;

    // read-before-write array model
    initial arr_rd_data = '0;
    always @(posedge clk) begin
        if (arr_wr_en) mem[arr_wr_addr] <= arr_wr_data;
        if (arr_rd_en) arr_rd_data <= mem[arr_rd_addr];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every response pops one expected value
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected got=%0h at %0t", rsp_data, $time);
            end else begin
                chk("rsp_data", 128'(rsp_data), 128'(sb_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // checks one full clear sweep starting at the next negedge, then RUN entry
    task automatic sweep_check();
        for (int i = 0; i < DP; i++) begin
            @(negedge clk);
            chk($sformatf("sweep_%0d", i),
                128'({arr_wr_en, arr_wr_addr, |arr_wr_data, wr_ready, rd_ready, arr_rd_en, init_done}),
                128'({1'b1, 8'(i), 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}));
            if (i == DP - 1) begin
                wr_valid = 2'b00;
                rd_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("init_done", 128'({init_done, rd_ready, arr_wr_en}), 128'(3'b110));
    endtask

    initial begin
        D0  = 104'h1111;
        D1  = 104'h2222;
        PA5 = {13{8'hA5}};
`ifdef ARF104B256E1R1W0CBBEHCAA4ACW_PORT_CTRL_BYPASS_EN
        exp4 = 104'h1;
`else
        exp4 = 104'h0;
`endif
        rst = 1'b0; init_req = 1'b0; wr_valid = '0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", 128'({init_done, wr_ready, rd_ready, rsp_valid, arr_wr_en, arr_rd_en}), 128'(0));
        chk("reset_bus", 128'({arr_wr_addr, |arr_wr_data, arr_rd_addr, |rsp_data}), 128'(0));

        // 1: post-reset sweep
        rst = 1'b1;
        sweep_check();

        // 2: round robin with both requesters held
        step();
        wr_valid = 2'b11; wr_addr[0] = 8'd5; wr_addr[1] = 8'd6; wr_data[0] = D0; wr_data[1] = D1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rr_gnt_%0d", k), 128'(wr_ready), 128'((k % 2 == 0) ? 2'b01 : 2'b10));
            chk($sformatf("rr_addr_%0d", k), 128'({arr_wr_en, arr_wr_addr}),
                128'({1'b1, (k % 2 == 0) ? 8'd5 : 8'd6}));
            chk($sformatf("rr_data_%0d", k), 128'(arr_wr_data), 128'((k % 2 == 0) ? D0 : D1));
            step();
        end
        wr_valid = 2'b00;

        // 3: write then read back, plus back-to-back reads
        wr_valid = 2'b01; wr_addr[0] = 8'd3; wr_data[0] = PA5;
        @(negedge clk);
        chk("wr3_ready", 128'(wr_ready), 128'(2'b01));
        step();
        wr_valid = 2'b00;
        rd_valid = 1'b1; rd_addr = 8'd3; sb_q.push_back(PA5);
        @(negedge clk);
        chk("rd3_port", 128'({rd_ready, arr_rd_en, arr_rd_addr}), 128'({2'b11, 8'd3}));
        step();
        rd_addr = 8'd5; sb_q.push_back(D0);
        step();
        rd_addr = 8'd6; sb_q.push_back(D1);
        step();
        rd_valid = 1'b0;

        // 4: same-address read/write collision
        wr_valid = 2'b01; wr_addr[0] = 8'd9; wr_data[0] = 104'h1;
        rd_valid = 1'b1; rd_addr = 8'd9; sb_q.push_back(exp4);
        step();
        wr_valid = 2'b00; sb_q.push_back(104'h1);
        step();
        rd_valid = 1'b0;

        // 5: init_req in RUN with an accepted read and write
        init_req = 1'b1; rd_valid = 1'b1; rd_addr = 8'd3; sb_q.push_back(PA5);
        wr_valid = 2'b01; wr_addr[0] = 8'd7; wr_data[0] = 104'h77;
        @(negedge clk);
        chk("initreq_wr", 128'({arr_wr_en, arr_wr_addr, arr_rd_en}), 128'({1'b1, 8'd7, 1'b1}));
        step();
        init_req = 1'b0; rd_addr = 8'd6; wr_valid = 2'b11;
        sweep_check();
        step();
        rd_valid = 1'b1; rd_addr = 8'd7; sb_q.push_back('0);
        step();
        rd_addr = 8'd3; sb_q.push_back('0);
        step();
        rd_valid = 1'b0;

        // 6: reset mid-sweep at cnt=100
        wr_valid = 2'b01; wr_addr[0] = 8'd9; wr_data[0] = 104'h55;
        step();
        wr_valid = 2'b00;
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        for (int i = 0; i <= 100; i++) @(negedge clk);
        chk("sweep_at_100", 128'({arr_wr_en, arr_wr_addr}), 128'({1'b1, 8'd100}));
        #1 rst = 1'b0;
        #1;
        chk("midreset_ctl", 128'({init_done, wr_ready, rd_ready, rsp_valid, arr_wr_en, arr_rd_en}), 128'(0));
        chk("midreset_bus", 128'({arr_wr_addr, |arr_wr_data, arr_rd_addr, |rsp_data}), 128'(0));
        step();
        rst = 1'b1;
        sweep_check();
        step();
        rd_valid = 1'b1; rd_addr = 8'd9; sb_q.push_back('0);
        step();
        rd_valid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 128'(sb_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
